// File: rtl/mips_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALU/PC mux selects and the control output bundle.
package mips_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADR   = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_ADDI_EX   = 4'd9,
    ST_ADDI_WB   = 4'd10,
    ST_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG_A  = 2'b11;

  localparam logic [1:0] ALU_B_REG      = 2'b00;
  localparam logic [1:0] ALU_B_FOUR     = 2'b01;
  localparam logic [1:0] ALU_B_IMM      = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SHL2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational map from FSM state (plus jr_control, rst) to datapath controls.
// Zero latency; no backpressure -- every state is a single cycle.
module control_decode
  import mips_control_pkg::*;
(
  input  state_t state,
  input  logic   jr_control,
  input  logic   rst,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    if (rst) begin
      // Selects park at their fetch values; every enable stays low.
      ctrl.alu_src_b = ALU_B_FOUR;
      ctrl.alu_op    = ALU_OP_ADD;
      ctrl.pc_src    = PC_SRC_ALU;
    end else begin
      case (state)
        ST_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.alu_src_b = ALU_B_FOUR;
          ctrl.alu_op    = ALU_OP_ADD;
          ctrl.pc_src    = PC_SRC_ALU;
        end
        ST_DECODE: begin
          ctrl.alu_src_b = ALU_B_IMM_SHL2;
          ctrl.alu_op    = ALU_OP_ADD;
        end
        ST_MEM_ADR, ST_ADDI_EX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALU_B_IMM;
        end
        ST_MEM_READ: begin
          ctrl.iord     = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        ST_MEM_WB: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
        end
        ST_MEM_WRITE: begin
          ctrl.iord      = 1'b1;
          ctrl.mem_write = 1'b1;
        end
        ST_EXECUTE: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALU_B_REG;
          ctrl.alu_op    = ALU_OP_FUNCT;
          // jr redirects the PC straight from register A and skips writeback.
          if (jr_control) begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SRC_REG_A;
          end
        end
        ST_ALU_WB: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        ST_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_op        = ALU_OP_SUB;
          ctrl.pc_src        = PC_SRC_ALUOUT;
          ctrl.pc_write_cond = 1'b1;
        end
        ST_ADDI_WB: ctrl.reg_write = 1'b1;
        ST_JUMP: begin
          ctrl.pc_src   = PC_SRC_JUMP;
          ctrl.pc_write = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/main_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic, output decode.
// One cycle per state, no stalls; outputs follow the state register (jr is the one Mealy term).
module main_control
  import mips_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       jr_control,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADR;
          OP_RTYPE:     state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDI_EX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADR: begin
        if (opcode == OP_LW)      state_d = ST_MEM_READ;
        else if (opcode == OP_SW) state_d = ST_MEM_WRITE;
        else                      state_d = ST_FETCH;
      end
      ST_MEM_READ: state_d = ST_MEM_WB;
      ST_EXECUTE:  state_d = jr_control ? ST_FETCH : ST_ALU_WB;
      ST_ADDI_EX:  state_d = ST_ADDI_WB;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  control_decode u_decode (
    .state      (state_q),
    .jr_control (jr_control),
    .rst        (rst),
    .ctrl       (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_src        = ctrl.pc_src;

  assign illegal_op = !rst && (state_q == ST_DECODE) && !is_legal_op(opcode);
  assign state      = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_main_control.sv
// Directed bench for main_control: walks each instruction class through its
// state sequence and compares every control output against hand-derived values.
module tb_main_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       jr_control;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  main_control dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .jr_control    (jr_control),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  // {pw,pwc,iord,mr,mw,irw,rd,m2r,rw,asa,asb[2],aop[2],psrc[2],ill,state[4]}
  logic [20:0] obs;
  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_src, illegal_op, state};

  task automatic check_val(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Hand-written table of the expected output word per state.
  function automatic logic [20:0] exp_vec(input int st, input bit jr, input bit ill, input bit in_rst);
    logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    logic [3:0] s;
    s = st[3:0];
    if (in_rst) begin
      asb = 2'b01;
      s   = 4'd0;
    end else begin
      case (st)
        0:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
        1:  asb = 2'b11;
        2:  begin asa = 1; asb = 2'b10; end
        3:  begin io = 1; mr = 1; end
        4:  begin m2r = 1; rw = 1; end
        5:  begin io = 1; mw = 1; end
        6:  begin asa = 1; aop = 2'b10; if (jr) begin pw = 1; psrc = 2'b11; end end
        7:  begin rd = 1; rw = 1; end
        8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pwc = 1; end
        9:  begin asa = 1; asb = 2'b10; end
        10: rw = 1;
        11: begin psrc = 2'b10; pw = 1; end
        default: ;
      endcase
    end
    return {pw, pwc, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, ill, s};
  endfunction

  // Called #1 after a rising edge; leaves the bench #1 after the edge that
  // follows the last listed state.
  task automatic run_instr(input string name, input logic [5:0] op, input bit jr_hold,
                           input bit jr_exec, input bit ill, input int n, input int st[6]);
    for (int i = 0; i < n; i++) begin
      opcode     = op;
      jr_control = jr_hold || (jr_exec && st[i] == 6);
      #1;
      check_val($sformatf("%s c%0d st%0d", name, i, st[i]), obs,
                exp_vec(st[i], jr_control, ill && st[i] == 1, 1'b0));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    opcode     = 6'b100011;
    jr_control = 1'b0;
    @(posedge clk);
    #1;
    check_val("reset", obs, exp_vec(0, 1'b0, 1'b0, 1'b1));
    @(posedge clk);
    #1;
    check_val("reset hold", obs, exp_vec(0, 1'b0, 1'b0, 1'b1));
    rst = 1'b0;

    run_instr("lw",    6'b100011, 0, 0, 0, 5, '{0, 1, 2, 3, 4, 0});
    run_instr("sw",    6'b101011, 0, 0, 0, 4, '{0, 1, 2, 5, 0, 0});
    run_instr("add",   6'b000000, 0, 0, 0, 4, '{0, 1, 6, 7, 0, 0});
    run_instr("jr",    6'b000000, 0, 1, 0, 3, '{0, 1, 6, 0, 0, 0});
    run_instr("beq",   6'b000100, 0, 0, 0, 3, '{0, 1, 8, 0, 0, 0});
    run_instr("j",     6'b000010, 0, 0, 0, 3, '{0, 1, 11, 0, 0, 0});
    run_instr("addi",  6'b001000, 0, 0, 0, 4, '{0, 1, 9, 10, 0, 0});
    run_instr("ill",   6'b111111, 0, 0, 1, 2, '{0, 1, 0, 0, 0, 0});
    run_instr("ill2",  6'b010101, 0, 0, 1, 2, '{0, 1, 0, 0, 0, 0});
    // jr_control held high outside EXECUTE must have no effect.
    run_instr("addi_jr", 6'b001000, 1, 0, 0, 4, '{0, 1, 9, 10, 0, 0});
    run_instr("lw_jr",   6'b100011, 1, 0, 0, 5, '{0, 1, 2, 3, 4, 0});

    // Abort a lw in MEM_READ: no MEM_WB writeback, restart at FETCH.
    run_instr("lw_abort", 6'b100011, 0, 0, 0, 3, '{0, 1, 2, 0, 0, 0});
    check_val("pre-abort in MEM_READ", obs, exp_vec(3, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    check_val("abort rst cycle", obs, exp_vec(3, 1'b0, 1'b0, 1'b1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("after abort", obs, exp_vec(0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    run_instr("post-abort", 6'b100011, 0, 0, 0, 5, '{1, 2, 3, 4, 0, 0});
    check_val("final fetch", obs, exp_vec(1, 1'b0, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/main_control.md
# main_control

Multicycle main control FSM for the MIPS core: steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath enable and mux select, including the 2-bit `alu_op` consumed by the downstream ALU control and JR control decoders. It takes their `jr_control` result back to redirect the PC for `jr`. It sits between the instruction register opcode field and the multicycle datapath.

## Interface
Parameters: none. All encodings are fixed in `mips_control_pkg`.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  IR[31:26]
- `jr_control`  in  1  from JR control; high when `alu_op`=10 and funct=001000
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load qualified by ALU zero in the datapath
- `iord`  out  1  memory address select: 0=PC, 1=ALUOut
- `mem_read`  out  1  memory read
- `mem_write`  out  1  memory write
- `ir_write`  out  1  IR load
- `reg_dst`  out  1  0=rt, 1=rd
- `mem_to_reg`  out  1  0=ALUOut, 1=MDR
- `reg_write`  out  1  register file write
- `alu_src_a`  out  1  0=PC, 1=A
- `alu_src_b`  out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
- `alu_op`  out  2  00=add, 01=sub, 10=funct field
- `pc_src`  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=register A (JR)
- `illegal_op`  out  1  one-cycle pulse on an unknown opcode
- `state`  out  4  current state, for debug

## Operation
- States are encoded 0–11: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- Outputs decode from the state register. Any output not listed for a state is 0.
  - FETCH: `mem_read`, `ir_write`, `pc_write`; `alu_src_b`=01; `alu_op`=00; `pc_src`=00. Next state: DECODE.
  - DECODE: `alu_src_b`=11; `alu_op`=00. Next state by opcode: lw/sw→MEM_ADR, R→EXECUTE, beq→BRANCH, addi→ADDI_EX, j→JUMP. Any other opcode→FETCH with `illegal_op`=1 during DECODE.
  - MEM_ADR: `alu_src_a`=1; `alu_src_b`=10. Next state: lw→MEM_READ, sw→MEM_WRITE.
  - MEM_READ: `iord`, `mem_read`. Next: MEM_WB.
  - MEM_WB: `mem_to_reg`, `reg_write`. Next: FETCH.
  - MEM_WRITE: `iord`, `mem_write`. Next: FETCH.
  - EXECUTE: `alu_src_a`=1; `alu_src_b`=00; `alu_op`=10.
    - `jr_control`=1: also `pc_write`=1, `pc_src`=11 (the one Mealy output); next FETCH.
    - Otherwise: next ALU_WB.
  - ALU_WB: `reg_dst`, `reg_write`. Next: FETCH.
  - BRANCH: `alu_src_a`=1; `alu_op`=01; `pc_src`=01; `pc_write_cond`. Next: FETCH.
  - ADDI_EX: `alu_src_a`=1; `alu_src_b`=10. Next: ADDI_WB.
  - ADDI_WB: `reg_write`. Next: FETCH.
  - JUMP: `pc_src`=10; `pc_write`. Next: FETCH.
- The opcode is sampled in DECODE and in MEM_ADR. The IR is stable after FETCH, so it is not re-latched.
- Unused state codes 12–15 go to FETCH on the next edge. All outputs are 0 while in them; `illegal_op` stays 0.

## Timing
- Reset:
  - `rst` high at an edge loads FETCH.
  - While `rst` is high, `pc_write`, `pc_write_cond`, `ir_write`, `mem_write`, `reg_write`, `mem_read` and `illegal_op` are forced to 0.
  - The mux selects show FETCH values; `state`=0.
- Reset asserted mid-instruction aborts it. No writeback occurs, and the first cycle after `rst` falls is FETCH.
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type 4
  - jr 3 (no `reg_write` is ever asserted)
  - beq 3
  - j 3
  - addi 4
  - illegal 2
- Each state lasts exactly one cycle. There are no stalls and no wait states.
- `jr_control` is used only in EXECUTE and ignored in every other state.

## Structure
- `mips_control_pkg` holds:
  - the state enum (4-bit)
  - opcode localparams
  - `alu_op` constants (ADD, SUB, FUNCT)
  - `pc_src` and `alu_src_b` constants
- It is shared with the ALU control and JR control decoders.
- Natural sub-module: `control_decode`, a purely combinational map from state, `jr_control` and `rst` to the output bundle. `main_control` keeps the state register and next-state logic.

## Test plan
- Reset then lw (opcode 100011): states 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in state 4.
- R-type add (funct 100000, `jr_control`=0): states 0,1,6,7,0. `alu_op`=10 in state 6; `reg_dst`=1 and `reg_write`=1 in state 7.
- jr (R-type, `jr_control`=1 in EXECUTE): states 0,1,6,0. `pc_write`=1 and `pc_src`=11 in state 6; `reg_write` never 1.
- beq then j: beq gives states 0,1,8 with `pc_write_cond`=1, `alu_op`=01. j gives states 0,1,11 with `pc_src`=10, `pc_write`=1.
- Opcode 111111: states 0,1,0. `illegal_op`=1 for exactly the DECODE cycle.
- `rst` asserted in MEM_READ of a lw: all enables 0 that cycle, next state 0, no `reg_write` for the aborted lw.
